float_scale_sched: RTL and testbench

// - Shares one power-of-two exponent-adjust datapath between NUM_REQ requesters.
// - Result = float * 2^shift, optionally negated.
// - Round-robin arbitration; iterative FSM applies at most MAX_STEP of exponent change per cycle.
// - Sits between producers (e.g. per-lane normalisers) and a single float consumer.

---
 rtl/float_scale_sched.sv | 191 +++++++++++++++++++
 tb/tb_float_scale_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_scale_sched.sv
// float_scale_sched: round-robin shared power-of-two scaler (float * 2^shift, optional negate).
// Define FLOAT_SCALE_SAT_EN for saturating exponent with {overflow, underflow} flags.
module float_scale_sched #(
   parameter int SIZE     = 32,
   parameter int NUM_REQ  = 4,
   parameter int SHIFT_W  = 8,
   parameter int MAX_STEP = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [NUM_REQ-1:0]         req_valid_in,
   output logic [NUM_REQ-1:0]         req_ready_out,
   input  logic [NUM_REQ*SIZE-1:0]    req_float_in,
   input  logic [NUM_REQ*SHIFT_W-1:0] req_shift_in,
   input  logic [NUM_REQ-1:0]         req_negate_in,
   output logic                       res_valid_out,
   input  logic                       res_ready_in,
   output logic [SIZE-1:0]            res_float_out,
   output logic [$clog2(NUM_REQ)-1:0] res_id_out,
   output logic [1:0]                 res_flags_out
);
   localparam int EXP_W  = (SIZE == 64) ? 11 : 8;
   localparam int MANT_W = SIZE - 1 - EXP_W;
   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int XW     = EXP_W + 2;
   localparam int RW     = SHIFT_W + 1;
`ifdef FLOAT_SCALE_SAT_EN
   localparam logic signed [XW-1:0] EXP_ALL1 = {2'b00, {EXP_W{1'b1}}};
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
`endif

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCALE = 2'd1, ST_DONE = 2'd2} state_t;

   state_t                 r_state, w_state_nxt;
   logic [ID_W-1:0]        r_rr, r_id, w_grant;
   logic                   r_sign, r_neg, r_special;
   logic signed [XW-1:0]   r_exp, w_exp_sum;
   logic [MANT_W-1:0]      r_mant;
   logic signed [RW-1:0]   r_rem, w_step, w_rem_nxt;
   logic                   w_found, w_sat_hi, w_sat_lo, w_scale_end;
   logic [NUM_REQ-1:0]     w_ready;
   logic [SIZE-1:0]        w_sel_float, w_res_float, r_res_float;
   logic [SHIFT_W-1:0]     w_sel_shift;
   logic [EXP_W-1:0]       w_sel_exp;
   logic                   r_res_valid;
   logic [ID_W-1:0]        r_res_id;

   assign w_sel_float   = req_float_in[int'(w_grant)*SIZE +: SIZE];
   assign w_sel_shift   = req_shift_in[int'(w_grant)*SHIFT_W +: SHIFT_W];
   assign w_sel_exp     = w_sel_float[SIZE-2 -: EXP_W];
   assign req_ready_out = w_ready;
   assign res_valid_out = r_res_valid;
   assign res_float_out = r_res_float;
   assign res_id_out    = r_res_id;

   // Round-robin pick: first valid requester at or after the pointer wins
   always_comb begin
      w_grant = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_grant = req_valid_in[(int'(r_rr) + k) % NUM_REQ] ? ID_W'((int'(r_rr) + k) % NUM_REQ) : w_grant;
      end
      w_found = |req_valid_in;
      w_ready = '0;
      w_ready[w_grant] = (r_state == ST_IDLE) && w_found && rst_n_in;
   end

   // One bounded exponent step per SCALE cycle and the resulting float
   always_comb begin
      w_step = r_rem;
      if (int'(r_rem) > MAX_STEP) begin
         w_step = RW'(MAX_STEP);
      end else if (int'(r_rem) < -MAX_STEP) begin
         w_step = RW'(-MAX_STEP);
      end else begin
         w_step = r_rem;
      end
      w_rem_nxt = r_rem - w_step;
      w_exp_sum = XW'(int'(r_exp) + int'(w_step));
`ifdef FLOAT_SCALE_SAT_EN
      w_sat_hi = ~r_special & (w_exp_sum >= EXP_ALL1);
      w_sat_lo = ~r_special & (w_exp_sum <= EXP_ZERO);
`else
      w_sat_hi = 1'b0;
      w_sat_lo = 1'b0;
`endif
      w_scale_end = r_special | (w_rem_nxt == '0) | w_sat_hi | w_sat_lo;
      if (r_special) begin
         w_res_float = {r_sign ^ r_neg, r_exp[EXP_W-1:0], r_mant};
      end else if (w_sat_hi) begin
         w_res_float = {r_sign ^ r_neg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      end else if (w_sat_lo) begin
         w_res_float = {r_sign ^ r_neg, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
      end else begin
         w_res_float = {r_sign ^ r_neg, w_exp_sum[EXP_W-1:0], r_mant};
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  w_state_nxt = w_found ? ST_SCALE : ST_IDLE;
         ST_SCALE: w_state_nxt = w_scale_end ? ST_DONE : ST_SCALE;
         ST_DONE:  w_state_nxt = res_ready_in ? ST_IDLE : ST_DONE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand capture on accept, exponent/remaining-shift update while scaling
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rr      <= '0;
         r_id      <= '0;
         r_sign    <= 1'b0;
         r_neg     <= 1'b0;
         r_special <= 1'b0;
         r_exp     <= '0;
         r_mant    <= '0;
         r_rem     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_rr      <= ID_W'((int'(w_grant) + 1) % NUM_REQ);
                  r_id      <= w_grant;
                  r_sign    <= w_sel_float[SIZE-1];
                  r_neg     <= req_negate_in[w_grant];
                  r_special <= (w_sel_exp == '0) || (w_sel_exp == {EXP_W{1'b1}});
                  r_exp     <= {2'b00, w_sel_exp};
                  r_mant    <= w_sel_float[MANT_W-1:0];
                  r_rem     <= {w_sel_shift[SHIFT_W-1], w_sel_shift};
               end else begin
                  r_rr <= r_rr;
               end
            end
            ST_SCALE: begin
               r_exp <= {2'b00, w_exp_sum[EXP_W-1:0]};
               r_rem <= w_rem_nxt;
            end
            default: begin
               r_rr <= r_rr;
            end
         endcase
      end
   end

   // Result registers: loaded on the last SCALE cycle, held until consumed
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_res_valid <= 1'b0;
         r_res_float <= '0;
         r_res_id    <= '0;
      end else if ((r_state == ST_SCALE) && w_scale_end) begin
         r_res_valid <= 1'b1;
         r_res_float <= w_res_float;
         r_res_id    <= r_id;
      end else if ((r_state == ST_DONE) && res_ready_in) begin
         r_res_valid <= 1'b0;
      end else begin
         r_res_valid <= r_res_valid;
      end
   end

`ifdef FLOAT_SCALE_SAT_EN
   logic [1:0] r_res_flags;

   // Saturation flags captured alongside the result
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_res_flags <= 2'b00;
      end else if ((r_state == ST_SCALE) && w_scale_end) begin
         r_res_flags <= {w_sat_hi, w_sat_lo};
      end else begin
         r_res_flags <= r_res_flags;
      end
   end
   assign res_flags_out = r_res_flags;
`else
   assign res_flags_out = 2'b00;
`endif

endmodule

// File: tb/tb_float_scale_sched.sv
// Randomised scoreboard bench for float_scale_sched: arbitration, latency, results, stability, reset.
`timescale 1ns/1ps
module tb_float_scale_sched;
   localparam int SIZE = 32, NUM_REQ = 4, SHIFT_W = 8, MAX_STEP = 16, ID_W = 2;

   logic                       clk_in = 1'b0;
   logic                       rst_n_in;
   logic [NUM_REQ-1:0]         req_valid_in, req_ready_out, req_negate_in;
   logic [NUM_REQ*SIZE-1:0]    req_float_in;
   logic [NUM_REQ*SHIFT_W-1:0] req_shift_in;
   logic                       res_valid_out, res_ready_in;
   logic [SIZE-1:0]            res_float_out;
   logic [ID_W-1:0]            res_id_out;
   logic [1:0]                 res_flags_out;

   float_scale_sched #(.SIZE(SIZE), .NUM_REQ(NUM_REQ), .SHIFT_W(SHIFT_W), .MAX_STEP(MAX_STEP)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_float_in(req_float_in), .req_shift_in(req_shift_in), .req_negate_in(req_negate_in),
      .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
      .res_float_out(res_float_out), .res_id_out(res_id_out), .res_flags_out(res_flags_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct { logic [31:0] f; int id; logic [1:0] fl; int lat; int acc; } exp_t;

   exp_t        sb[$];
   int          id_log[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, acc_cyc = -1, hs_cyc = -1, rr = 0, refill_left = 0;
   bit          busy = 1'b0;
   logic        p_valid[NUM_REQ];
   logic [31:0] p_float[NUM_REQ];
   logic [7:0]  p_shift[NUM_REQ];
   logic        p_neg[NUM_REQ];
   bit          accepted[NUM_REQ];
   logic [31:0] last_float;
   logic [1:0]  last_flags;
   int          last_lat = 0, last_id = 0, cur_lat = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: result = float * 2^shift with wrap (default) or saturation, plus SCALE-cycle count
   task automatic ref_model(input logic [31:0] f, input logic [7:0] sh8, input logic neg,
                            output logic [31:0] r, output logic [1:0] fl, output int lat);
      int e, sh, rem, st, n;
      logic [31:0] t;
      e  = int'(f[30:23]);
      sh = int'($signed(sh8));
      fl = 2'b00;
      if (e == 0 || e == 255) begin
         t = f;
         n = 1;
      end else begin
`ifdef FLOAT_SCALE_SAT_EN
         rem = sh;
         n   = 0;
         do begin
            st = (rem > MAX_STEP) ? MAX_STEP : ((rem < -MAX_STEP) ? -MAX_STEP : rem);
            e += st;
            rem -= st;
            n++;
         end while (rem != 0 && e > 0 && e < 255);
         if (e >= 255) begin
            t = {f[31], 8'hFF, 23'h0};
            fl = 2'b10;
         end else if (e <= 0) begin
            t = {f[31], 31'h0};
            fl = 2'b01;
         end else begin
            t = {f[31], 8'(e), f[22:0]};
         end
`else
         n = (sh == 0) ? 1 : (((sh < 0) ? -sh : sh) + MAX_STEP - 1) / MAX_STEP;
         e = (e + sh) & 255;
         t = {f[31], 8'(e), f[22:0]};
`endif
      end
      t[31] = t[31] ^ neg;
      r   = t;
      lat = 1 + n;
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid_in[i]                  = p_valid[i];
         req_float_in[i*SIZE +: SIZE]     = p_float[i];
         req_shift_in[i*SHIFT_W +: SHIFT_W] = p_shift[i];
         req_negate_in[i]                 = p_neg[i];
      end
   endtask

   task automatic load(input int i, input logic [31:0] f, input logic [7:0] s, input logic n);
      p_valid[i] = 1'b1; p_float[i] = f; p_shift[i] = s; p_neg[i] = n;
      drive();
   endtask

   function automatic logic [31:0] rand_float();
      int s;
      logic [7:0] e;
      s = int'($urandom_range(0, 9));
      if (s == 0) e = 8'h00;
      else if (s == 1) e = 8'hFF;
      else if (s == 2) e = 8'($urandom_range(1, 20));
      else if (s == 3) e = 8'($urandom_range(235, 254));
      else e = 8'($urandom_range(1, 254));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accepted[i]) begin
            accepted[i] = 1'b0;
            p_valid[i]  = 1'b0;
            if (refill_left > 0) begin
               refill_left--;
               p_valid[i] = 1'b1;
            end
         end
      end
      drive();
   endtask

   function automatic bit any_pending();
      bit a = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) a |= p_valid[i];
      return a;
   endfunction

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || busy || any_pending()) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL drain_timeout: queue %0d busy %0d, expected empty within 300 cycles", sb.size(), busy);
      end
   endtask

   task automatic do_reset(input int n);
      rst_n_in = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin p_valid[i] = 1'b0; accepted[i] = 1'b0; end
      drive();
      sb.delete();
      busy = 1'b0; rr = 0; hs_cyc = -1; acc_cyc = -1;
      repeat (n) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   // Acceptor: predicts the round-robin grant and pushes the expected response
   initial begin
      int g;
      logic [NUM_REQ-1:0] er;
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            chk("ready_in_reset", 64'(req_ready_out), 64'(0));
         end else begin
            if (busy && hs_cyc > acc_cyc && hs_cyc < cyc) busy = 1'b0;
            er = '0;
            g  = -1;
            if (!busy) begin
               for (int k = NUM_REQ - 1; k >= 0; k--) if (p_valid[(rr + k) % NUM_REQ]) g = (rr + k) % NUM_REQ;
            end
            if (g >= 0) er[g] = 1'b1;
            chk("grant", 64'(req_ready_out), 64'(er));
            if (g >= 0) begin
               ref_model(p_float[g], p_shift[g], p_neg[g], e.f, e.fl, e.lat);
               e.id = g;
               e.acc = cyc;
               sb.push_back(e);
               busy = 1'b1; acc_cyc = cyc; rr = (g + 1) % NUM_REQ; accepted[g] = 1'b1;
            end
         end
      end
   end

   // Monitor: latency on first valid, stability while stalled, data on handshake
   initial begin
      bit seen = 1'b0;
      logic [31:0] h_f;
      logic [1:0] h_fl;
      logic [ID_W-1:0] h_id;
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (!rst_n_in) begin
            chk("valid_in_reset", 64'(res_valid_out), 64'(0));
            seen = 1'b0;
         end else if (res_valid_out) begin
            if (!seen) begin
               seen = 1'b1; h_f = res_float_out; h_fl = res_flags_out; h_id = res_id_out;
               cur_lat = cyc - ((sb.size() > 0) ? sb[0].acc : cyc);
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_result: got id %0d float %h, expected no result", res_id_out, res_float_out);
               end else begin
                  chk("latency", 64'(cur_lat), 64'(sb[0].lat));
               end
            end else begin
               chk("stable_float", 64'(res_float_out), 64'(h_f));
               chk("stable_flags", 64'(res_flags_out), 64'(h_fl));
               chk("stable_id", 64'(res_id_out), 64'(h_id));
            end
            if (res_ready_in) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("result_float", 64'(res_float_out), 64'(e.f));
                  chk("result_id", 64'(res_id_out), 64'(e.id));
                  chk("result_flags", 64'(res_flags_out), 64'(e.fl));
               end
               last_float = res_float_out; last_flags = res_flags_out;
               last_id = int'(res_id_out); last_lat = cur_lat;
               id_log.push_back(int'(res_id_out));
               hs_cyc = cyc;
               seen = 1'b0;
            end
         end else if (seen) begin
            checks++; errors++;
            $display("FAIL valid_dropped: got valid 0, expected 1 until accepted");
            seen = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      res_ready_in = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         p_valid[i] = 1'b0; p_float[i] = 32'h0; p_shift[i] = 8'h0; p_neg[i] = 1'b0; accepted[i] = 1'b0;
      end
      drive();
      @(posedge clk_in);
      #1;
      do_reset(3);
      chk("reset_float", 64'(res_float_out), 64'(0));
      chk("reset_id", 64'(res_id_out), 64'(0));
      chk("reset_flags", 64'(res_flags_out), 64'(0));
      res_ready_in = 1'b1;

      load(0, 32'h3F80_0000, 8'd3, 1'b0);
      wait_drain();
      chk("dir_sh3_float", 64'(last_float), 64'h4100_0000);
      chk("dir_sh3_id", 64'(last_id), 64'(0));
      chk("dir_sh3_lat", 64'(last_lat), 64'(2));

      load(2, 32'h3F80_0000, 8'd40, 1'b0);
      wait_drain();
      chk("dir_sh40_float", 64'(last_float), 64'h5380_0000);
      chk("dir_sh40_lat", 64'(last_lat), 64'(4));

      load(3, 32'h7FC0_0000, 8'd5, 1'b1);
      wait_drain();
      chk("dir_nan_float", 64'(last_float), 64'hFFC0_0000);
      chk("dir_nan_lat", 64'(last_lat), 64'(2));

`ifdef FLOAT_SCALE_SAT_EN
      load(1, 32'h3F80_0000, 8'h80, 1'b0);
      wait_drain();
      chk("sat_lo_float", 64'(last_float), 64'h0);
      chk("sat_lo_flags", 64'(last_flags), 64'(2'b01));
      load(1, 32'h7F00_0000, 8'd1, 1'b0);
      wait_drain();
      chk("sat_hi_float", 64'(last_float), 64'h7F80_0000);
      chk("sat_hi_flags", 64'(last_flags), 64'(2'b10));
`endif

      // all four requesting from pointer 0, requester 0 re-requests once
      do_reset(2);
      id_log.delete();
      refill_left = 1;
      for (int i = 0; i < NUM_REQ; i++) load(i, 32'h4000_0000 + 32'(i), 8'(i + 1), 1'b0);
      wait_drain();
      chk("rr_count", 64'(id_log.size()), 64'(5));
      for (int i = 0; i < 5; i++) chk("rr_order", 64'((i < id_log.size()) ? id_log[i] : -1), 64'(i % 4));

      // consumer stalls while another requester waits
      res_ready_in = 1'b0;
      load(1, 32'hC0A0_0000, 8'hFE, 1'b1);
      load(3, 32'h3F80_0000, 8'd7, 1'b0);
      repeat (9) tick();
      res_ready_in = 1'b1;
      wait_drain();

      // reset while scaling drops the request
      load(2, 32'h3F80_0000, 8'd40, 1'b0);
      n = 0;
      while (!busy && n < 20) begin tick(); n++; end
      tick();
      do_reset(2);
      repeat (6) tick();
      load(0, 32'h3F80_0000, 8'd3, 1'b0);
      wait_drain();
      chk("post_reset_float", 64'(last_float), 64'h4100_0000);
      chk("post_reset_id", 64'(last_id), 64'(0));

      // randomised traffic with back-pressure and withdrawn requests
      for (int c = 0; c < 500; c++) begin
         res_ready_in = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
               load(i, rand_float(), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end else if (p_valid[i] && $urandom_range(0, 29) == 0) begin
               p_valid[i] = 1'b0;
            end
         end
         drive();
         tick();
      end
      res_ready_in = 1'b1;
      wait_drain();
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
